// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Purpose:
//   Central freeze/bubble/flush controller for the ARM 5-stage pipeline
//   (PC, IF/ID, ID/EX, EXE/MEM, MEM/WB). Combines the hazard unit's stall
//   request, the EXE-stage taken-branch signal and the memory-stage handshake.
//   Owns the multi-cycle memory-wait FSM (RUN / MEM_WAIT), a sticky memory
//   timeout watchdog and optional stall/flush performance counters.
//
// Optional feature macro: STALL_PERF_CNT_EN
//   Defined   -> stall_cycles / flush_events are saturating counters.
//   Undefined -> no counter flops; both outputs are constant 0.
//
// Parameters:
//   MEM_TIMEOUT  wait cycles in MEM_WAIT before mem_timeout sets (2..65535)
//   CNT_W        width of the performance counters
//
// Ports:
//   clk              in   pipeline clock, rising edge
//   rst              in   synchronous active-high reset
//   hazard_Detected  in   stall request from the hazard detection unit
//   branch_taken     in   EXE-stage branch resolved taken
//   mem_req          in   MEM stage holds a load/store for the memory controller
//   mem_ready        in   memory controller completes the access this cycle
//   freeze_front     out  hold PC and IF/ID
//   bubble_id_ex     out  load a NOP into ID/EX
//   flush_if_id      out  clear IF/ID
//   freeze_back      out  hold ID/EX, EXE/MEM and MEM/WB
//   mem_timeout      out  sticky watchdog error
//   stall_cycles     out  front-end stall cycle count
//   flush_events     out  taken-branch flush count
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_Detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             freeze_back,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = 16'(MEM_TIMEOUT);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_cnt_next;
  logic        r_mem_timeout;
  logic        w_mem_timeout_next;
  logic        w_mem_stall;
  logic        w_freeze_front;
  logic        w_bubble_id_ex;
  logic        w_flush_if_id;
  logic        w_freeze_back;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_wait_cnt    <= w_wait_cnt_next;
      r_mem_timeout <= w_mem_timeout_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_mem_stall     = 1'b0;
    w_freeze_front  = 1'b0;
    w_bubble_id_ex  = 1'b0;
    w_flush_if_id   = 1'b0;
    w_freeze_back   = 1'b0;

    case (r_state)
      ST_RUN: begin
        // mem_req with mem_ready in the same cycle is a zero-wait access.
        if (mem_req && !mem_ready) begin
          w_mem_stall     = 1'b1;
          w_state_next    = ST_MEM_WAIT;
          w_wait_cnt_next = 16'd1;
        end
      end
      ST_MEM_WAIT: begin
        // mem_req is deliberately not examined: a dropped request without
        // mem_ready keeps us waiting so the watchdog can catch it.
        if (!mem_ready) begin
          w_mem_stall = 1'b1;
          if (r_wait_cnt != 16'hFFFF) begin
            w_wait_cnt_next = r_wait_cnt + 16'd1;
          end
        end else begin
          w_state_next    = ST_RUN;
          w_wait_cnt_next = '0;
        end
      end
      default: begin
        w_state_next    = ST_RUN;
        w_wait_cnt_next = '0;
      end
    endcase

    // While the memory stalls, the whole pipeline is frozen and front-end
    // requests are re-presented later, so they are ignored here.
    if (w_mem_stall) begin
      w_freeze_front = 1'b1;
      w_freeze_back  = 1'b1;
    end else if (branch_taken) begin
      // ID instruction is squashed, so a concurrent hazard is irrelevant;
      // PC must advance to the branch target.
      w_flush_if_id  = 1'b1;
      w_bubble_id_ex = 1'b1;
    end else if (hazard_Detected) begin
      w_freeze_front = 1'b1;
      w_bubble_id_ex = 1'b1;
    end
  end

  // Set on the same edge the wait counter lands on the limit, so the flag
  // and the counter value become visible together.
  assign w_mem_timeout_next = r_mem_timeout |
                              ((w_state_next == ST_MEM_WAIT) &&
                               (w_wait_cnt_next >= LP_TIMEOUT));

  assign freeze_front = w_freeze_front & ~rst;
  assign bubble_id_ex = w_bubble_id_ex & ~rst;
  assign flush_if_id  = w_flush_if_id  & ~rst;
  assign freeze_back  = w_freeze_back  & ~rst;
  assign mem_timeout  = r_mem_timeout;

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (freeze_front && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (flush_if_id && (r_flush_events != {CNT_W{1'b1}})) begin
        r_flush_events <= r_flush_events + 1'b1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_controller
//
// Table-driven directed bench for pipeline_stall_controller (MEM_TIMEOUT=4).
// Each table row is one clock cycle: inputs are driven after the falling
// edge and outputs are sampled 1 time unit before the next rising edge, so
// combinational controls reflect this cycle's inputs and registered outputs
// (mem_timeout, counters) reflect state up to the previous edge.
// Counter expectations apply when STALL_PERF_CNT_EN is defined; otherwise 0.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             hazard_Detected;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             freeze_front;
  logic             bubble_id_ex;
  logic             flush_if_id;
  logic             freeze_back;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  int n_vec;
  int n_bad;

  pipeline_stall_controller #(
    .MEM_TIMEOUT (4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_Detected (hazard_Detected),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .freeze_front    (freeze_front),
    .bubble_id_ex    (bubble_id_ex),
    .flush_if_id     (flush_if_id),
    .freeze_back     (freeze_back),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic hz;
    logic br;
    logic req;
    logic rdy;
    logic ff;
    logic bub;
    logic fl;
    logic fb;
    logic to;
    int   stall;
    int   flush;
  } vec_t;

  vec_t tbl[27];

  task automatic apply_check(input string name, input vec_t v);
    logic [4:0] got_ctl;
    logic [4:0] exp_ctl;
    int         exp_stall;
    int         exp_flush;
    @(negedge clk);
    rst             = v.rst;
    hazard_Detected = v.hz;
    branch_taken    = v.br;
    mem_req         = v.req;
    mem_ready       = v.rdy;
    #4;
`ifdef STALL_PERF_CNT_EN
    exp_stall = v.stall;
    exp_flush = v.flush;
`else
    exp_stall = 0;
    exp_flush = 0;
`endif
    got_ctl = {freeze_front, bubble_id_ex, flush_if_id, freeze_back, mem_timeout};
    exp_ctl = {v.ff, v.bub, v.fl, v.fb, v.to};
    n_vec++;
    if (got_ctl !== exp_ctl || stall_cycles !== CNT_W'(exp_stall) ||
        flush_events !== CNT_W'(exp_flush)) begin
      n_bad++;
      $display("FAIL %s: ff/bub/fl/fb/to got %b want %b, stall got %0d want %0d, flush got %0d want %0d",
               name, got_ctl, exp_ctl, stall_cycles, exp_stall, flush_events, exp_flush);
    end else begin
      $display("ok   %s: ff/bub/fl/fb/to=%b stall=%0d flush=%0d",
               name, got_ctl, stall_cycles, flush_events);
    end
  endtask

  initial begin
    vec_t v;
    n_vec = 0;
    n_bad = 0;

    //              rst hz br rq rd | ff bb fl fb to | stall flush
    tbl[0]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,  0, 0}; // outputs gated in rst
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,  0, 0};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,  0, 0}; // hazard
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0,  1, 0};
    tbl[4]  = '{1'b0,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0,  2, 0}; // branch beats hazard
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,  2, 1};
    tbl[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,  2, 1}; // mem wait, br ignored
    tbl[7]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,  3, 1};
    tbl[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,  4, 1};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b0,1'b0,  5, 1}; // ready: branch flushes
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,  5, 2}; // back in RUN
    tbl[11] = '{1'b0,1'b1,1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b0,1'b0,  5, 2}; // single-cycle access
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,  6, 2};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,  6, 2}; // cnt -> 1
    tbl[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,  7, 2}; // cnt -> 2
    tbl[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,  8, 2}; // cnt -> 3
    tbl[16] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,  9, 2}; // cnt -> 4
    tbl[17] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1, 10, 2}; // timeout visible
    tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1, 11, 2}; // req dropped: keep waiting
    tbl[19] = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1, 12, 2}; // ready
    tbl[20] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 12, 2}; // sticky
    tbl[21] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 12, 2}; // rst edge pending
    tbl[22] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,  0, 0};
    tbl[23] = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,  0, 0}; // enter MEM_WAIT
    tbl[24] = '{1'b0,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0,  1, 0}; // hazard ignored
    tbl[25] = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,  2, 0}; // rst in MEM_WAIT
    tbl[26] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0,  0, 0}; // RUN, nothing held

    rst             = 1'b1;
    hazard_Detected = 1'b0;
    branch_taken    = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 27; i++) begin
      apply_check($sformatf("row%0d", i), tbl[i]);
    end

    // Long memory wait: timeout must rise after exactly 4 waiting edges,
    // survive completion, and clear only on reset. Stall counter starts at 0.
    for (int i = 0; i < 8; i++) begin
      v = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0, i, 0};
      v.to = (i >= 4);
      apply_check($sformatf("longwait%0d", i), v);
    end
    v = '{1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b0,1'b1, 8, 0};
    apply_check("longwait_done", v);
    v = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1, 8, 1};
    apply_check("after_done_hazard", v);
    v = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 9, 1};
    apply_check("final_rst", v);
    v = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0, 0};
    apply_check("post_rst_clear", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the hazard detector's stall request, the EXE-stage branch-taken signal and the SRAM/memory-stage handshake.
- Drives the freeze, bubble and flush controls for the ARM 5-stage pipeline (PC, IF/ID, ID/EX, EXE/MEM, MEM/WB).
- Owns the multi-cycle memory-wait state machine, a memory-timeout watchdog and optional stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 64: wait cycles in MEM_WAIT before mem_timeout is set; legal range 2..65535.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous, active-high reset
- hazard_Detected  in  1  stall request from the hazard detection unit
- branch_taken  in  1  EXE-stage branch resolved taken
- mem_req  in  1  MEM stage holds a load/store needing the memory controller
- mem_ready  in  1  memory controller completes the current access this cycle
- freeze_front  out  1  hold PC and IF/ID
- bubble_id_ex  out  1  load NOP (all control bits 0) into ID/EX
- flush_if_id  out  1  clear IF/ID
- freeze_back  out  1  hold ID/EX, EXE/MEM and MEM/WB
- mem_timeout  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  front-end stall cycle count
- flush_events  out  CNT_W  taken-branch flush count

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- States: RUN (reset state) and MEM_WAIT. The state register, the wait counter (16 bit) and mem_timeout are registered. The four control outputs are combinational from state and inputs, so a stall takes effect in the same cycle the request is raised.
- Reset: state=RUN, wait counter=0, mem_timeout=0, counters=0. All control outputs are 0 while rst=1.
- RUN, evaluated in priority order:
  1. mem_req=1 and mem_ready=0: freeze_front=1, freeze_back=1, bubble_id_ex=0, flush_if_id=0; next state MEM_WAIT; wait counter=1.
  2. branch_taken=1: flush_if_id=1, bubble_id_ex=1, freeze_front=0 (PC loads the branch target). hazard_Detected is ignored because the ID instruction is squashed.
  3. hazard_Detected=1: freeze_front=1, bubble_id_ex=1.
  4. Otherwise: all control outputs 0.
- MEM_WAIT, mem_ready=0:
  - freeze_front=1, freeze_back=1, bubble_id_ex=0, flush_if_id=0.
  - hazard_Detected and branch_taken are ignored; the pipeline is frozen, so both inputs are re-presented once it advances.
  - Wait counter increments and saturates at 0xFFFF.
  - When the wait counter reaches MEM_TIMEOUT, mem_timeout is set and held until rst. The FSM keeps waiting.
- MEM_WAIT, mem_ready=1:
  - freeze_back=0 and the access completes this cycle.
  - Front-end outputs follow RUN rules 2-4 in the same cycle.
  - Next state RUN; wait counter clears.
- mem_req=1 with mem_ready=1 in RUN is a single-cycle access: no wait, RUN rules 2-4 apply.
- mem_req dropping in MEM_WAIT without mem_ready is a protocol violation. The FSM stays in MEM_WAIT and relies on the watchdog.
- rst asserted in MEM_WAIT returns the FSM to RUN on the next edge. No outputs are held over.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined:
  - stall_cycles increments in every cycle with freeze_front=1.
  - flush_events increments in every cycle with flush_if_id=1.
  - Both saturate at all-ones and clear on rst.
- Undefined: no counter flops are built; stall_cycles and flush_events are constant 0.

Test Plan:
- Reset then hazard_Detected=1 for 2 cycles -> freeze_front=1, bubble_id_ex=1 in both cycles; freeze_back=0; stall_cycles=2 (with STALL_PERF_CNT_EN).
- branch_taken=1 and hazard_Detected=1 in the same cycle -> flush_if_id=1, bubble_id_ex=1, freeze_front=0; flush_events=1, stall_cycles unchanged.
- mem_req=1, mem_ready=0 for 3 cycles then 1 -> freeze_back=1 for 3 cycles and 0 on the 4th; state returns to RUN; a branch_taken held high throughout flushes only on the 4th cycle.
- mem_req=1, mem_ready=0 held with MEM_TIMEOUT=4 -> mem_timeout rises on the cycle the wait counter reaches 4 and stays 1 after mem_ready; cleared only by rst.
- rst pulsed while in MEM_WAIT -> next cycle all outputs 0, mem_timeout=0, counters=0, state RUN.
- Build without STALL_PERF_CNT_EN and repeat scenario 1 -> stall_cycles=0, flush_events=0; control outputs identical to the counters-enabled build.
